// File: rtl/muldiv_pkg.sv
// Shared constants and op-code helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN       = 32;
  localparam int N_ITER_DEF = 32;

  // M-extension op codes on the shared 5-bit ALU control bus.
  localparam logic [4:0] OPMUL    = 5'h10;
  localparam logic [4:0] OPMULH   = 5'h11;
  localparam logic [4:0] OPMULHSU = 5'h12;
  localparam logic [4:0] OPMULHU  = 5'h13;
  localparam logic [4:0] OPDIV    = 5'h14;
  localparam logic [4:0] OPDIVU   = 5'h15;
  localparam logic [4:0] OPREM    = 5'h16;
  localparam logic [4:0] OPREMU   = 5'h17;

  function automatic logic is_mdu_op(input logic [4:0] op);
    return op inside {OPMUL, OPMULH, OPMULHSU, OPMULHU, OPDIV, OPDIVU, OPREM, OPREMU};
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return op inside {OPDIV, OPDIVU, OPREM, OPREMU};
  endfunction

  // rs1 is treated as two's complement for these ops.
  function automatic logic a_is_signed(input logic [4:0] op);
    return op inside {OPMULH, OPMULHSU, OPDIV, OPREM};
  endfunction

  // rs2 is treated as two's complement for these ops.
  function automatic logic b_is_signed(input logic [4:0] op);
    return op inside {OPMULH, OPDIV, OPREM};
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Final sign correction, word select and special-case override for muldiv_unit.
module muldiv_signfix
  import muldiv_pkg::*;
(
  input  logic [63:0] prod,
  input  logic [31:0] quo,
  input  logic [31:0] rem,
  input  logic        sign_a,
  input  logic        sign_b,
  input  logic [4:0]  op,
  input  logic        div_zero,
  input  logic        ovf,
  output logic [31:0] result
);

  logic [63:0] prod_s;
  logic [31:0] quo_s;
  logic [31:0] rem_s;

  // Apply signs to the magnitude results, then pick the word the op asks for.
  // A zero divisor leaves |dividend| in the remainder, so REM/REMU return the
  // dividend through the normal path; only the quotient needs forcing.
  always_comb begin
    prod_s = (sign_a ^ sign_b) ? (~prod + 64'd1) : prod;
    quo_s  = (sign_a ^ sign_b) ? (~quo + 32'd1) : quo;
    rem_s  = sign_a ? (~rem + 32'd1) : rem;
    result = '0;
    case (op)
      OPMUL:                     result = prod_s[31:0];
      OPMULH, OPMULHSU, OPMULHU: result = prod_s[63:32];
      OPDIV, OPDIVU: begin
        if (div_zero)  result = 32'hFFFF_FFFF;
        else if (ovf)  result = 32'h8000_0000;
        else           result = quo_s;
      end
      OPREM, OPREMU: begin
        if (ovf)       result = '0;
        else           result = rem_s;
      end
      default:         result = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with fixed 34-cycle latency.
//
// state | meaning
// IDLE  | waiting for iStart with a valid M-op code
// CALC  | N_ITER shift-add / shift-subtract iterations
// FIX   | sign correction and special-case selection
// DONE  | publish oResult and pulse oDone
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int N_ITER = N_ITER_DEF
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iStart,
  input  logic [31:0] iA,
  input  logic [31:0] iB,
  input  logic [4:0]  iControl,
  output logic [31:0] oResult,
  output logic        oBusy,
  output logic        oDone,
  output logic        oZero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [4:0]  op_q, op_d;
  logic [31:0] a_mag_q, a_mag_d;
  logic [31:0] b_mag_q, b_mag_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic        div_zero_q, div_zero_d;
  logic        ovf_q, ovf_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] fix_q, fix_d;
  logic [31:0] result_q, result_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        st_sa, st_sb;
  logic [31:0] st_amag, st_bmag;
  logic [32:0] mul_sum;
  logic [32:0] div_shift, div_diff;
  logic [31:0] sf_result;

  muldiv_signfix u_signfix (
    .prod     (prod_q),
    .quo      (quo_q),
    .rem      (rem_q),
    .sign_a   (sign_a_q),
    .sign_b   (sign_b_q),
    .op       (op_q),
    .div_zero (div_zero_q),
    .ovf      (ovf_q),
    .result   (sf_result)
  );

  // Sequencing, operand capture and one datapath iteration per CALC cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_mag_d    = a_mag_q;
    b_mag_d    = b_mag_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    div_zero_d = div_zero_q;
    ovf_d      = ovf_q;
    prod_d     = prod_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    fix_d      = fix_q;
    result_d   = result_q;
    done_d     = 1'b0;
    // Busy is registered so it rises the cycle after the first CALC cycle
    // begins and drops together with the oDone pulse.
    busy_d     = (state_q == S_CALC) || (state_q == S_FIX);

    st_sa   = a_is_signed(iControl) & iA[31];
    st_sb   = b_is_signed(iControl) & iB[31];
    st_amag = st_sa ? (~iA + 32'd1) : iA;
    st_bmag = st_sb ? (~iB + 32'd1) : iB;

    // Radix-2 shift-add: the multiplier sits in the low half and is consumed
    // LSB first while partial sums accumulate in the high half.
    mul_sum = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, a_mag_q} : 33'd0);

    // Restoring division: quotient register doubles as the dividend shifter.
    div_shift = {rem_q, quo_q[31]};
    div_diff  = div_shift - {1'b0, b_mag_q};

    case (state_q)
      S_IDLE: begin
        if (iStart && is_mdu_op(iControl)) begin
          op_d       = iControl;
          sign_a_d   = st_sa;
          sign_b_d   = st_sb;
          a_mag_d    = st_amag;
          b_mag_d    = st_bmag;
          prod_d     = {32'd0, st_bmag};
          quo_d      = st_amag;
          rem_d      = '0;
          cnt_d      = '0;
          div_zero_d = (iB == 32'd0);
          ovf_d      = (iControl inside {OPDIV, OPREM}) &&
                       (iA == 32'h8000_0000) && (iB == 32'hFFFF_FFFF);
          state_d    = S_CALC;
        end
      end
      S_CALC: begin
        if (is_div_op(op_q)) begin
          if (!div_diff[32]) begin
            rem_d = div_diff[31:0];
            quo_d = {quo_q[30:0], 1'b1};
          end else begin
            rem_d = div_shift[31:0];
            quo_d = {quo_q[30:0], 1'b0};
          end
        end else begin
          prod_d = {mul_sum, prod_q[31:1]};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(N_ITER - 1)) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        fix_d   = sf_result;
        state_d = S_DONE;
      end
      S_DONE: begin
        result_d = fix_q;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      a_mag_q    <= '0;
      b_mag_q    <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
      prod_q     <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      fix_q      <= '0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      a_mag_q    <= a_mag_d;
      b_mag_q    <= b_mag_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      div_zero_q <= div_zero_d;
      ovf_q      <= ovf_d;
      prod_q     <= prod_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      fix_q      <= fix_d;
      result_q   <= result_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign oResult = result_q;
  assign oBusy   = busy_q;
  assign oDone   = done_q;
  assign oZero   = (result_q == 32'd0);

endmodule
